// File: rtl/control_sequencer.sv
// Microcoded fetch/decode/execute sequencer for the 8-bit bus CPU.
// The step counter runs T0..T4 or parks in HALTED. All strobes are a combinational decode of (step, opcode, flags).
module control_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                  i_CLOCK,
  input  logic                  i_CLEAR,
  input  logic [DATA_WIDTH-1:0] i_INSTRUCTION,
  input  logic                  i_ZERO_FLAG,
  input  logic                  i_CARRY_FLAG,
  output logic                  o_PC_OUT,
  output logic                  o_PC_INC,
  output logic                  o_PC_LOAD,
  output logic                  o_MAR_IN,
  output logic                  o_RAM_OUT,
  output logic                  o_RAM_IN,
  output logic                  o_IR_IN,
  output logic                  o_IR_OUT,
  output logic                  o_A_IN,
  output logic                  o_A_OUT,
  output logic                  o_B_IN,
  output logic                  o_ALU_OUT,
  output logic                  o_ALU_SUB,
  output logic                  o_FLAGS_IN,
  output logic                  o_OUT_IN,
  output logic                  o_HALT,
  output logic [2:0]            o_STEP
);

  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, HALTED = 3'd5} state_t;

  typedef struct packed {
    logic pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halt;
  } ctrl_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h3);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4'h4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'h5);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'h7);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(4'h8);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

  state_t                  r_state, w_next;
  ctrl_t                   w_ctrl, w_gated;
  logic [OPCODE_WIDTH-1:0] w_op;

  assign w_op = i_INSTRUCTION[DATA_WIDTH-1 -: OPCODE_WIDTH];

  always_ff @(posedge i_CLOCK or posedge i_CLEAR) begin
    if (i_CLEAR) r_state <= T0;
    else         r_state <= w_next;
  end

  always_comb begin
    w_ctrl = '0;
    w_next = T0;
    case (r_state)
      T0: begin
        w_ctrl.pc_out = 1'b1; w_ctrl.mar_in = 1'b1;
        w_next = T1;
      end
      T1: begin
        w_ctrl.ram_out = 1'b1; w_ctrl.ir_in = 1'b1; w_ctrl.pc_inc = 1'b1;
        w_next = T2;
      end
      T2: begin
        case (w_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            w_ctrl.ir_out = 1'b1; w_ctrl.mar_in = 1'b1;
            w_next = T3;
          end
          OP_LDI: begin w_ctrl.ir_out = 1'b1; w_ctrl.a_in = 1'b1; end
          OP_JMP: begin w_ctrl.ir_out = 1'b1; w_ctrl.pc_load = 1'b1; end
          // Flags only move on FLAGS_IN edges, so sampling them live here is safe
          OP_JC:  begin w_ctrl.ir_out = 1'b1; w_ctrl.pc_load = i_CARRY_FLAG; end
          OP_JZ:  begin w_ctrl.ir_out = 1'b1; w_ctrl.pc_load = i_ZERO_FLAG; end
          OP_OUT: begin w_ctrl.a_out = 1'b1; w_ctrl.out_in = 1'b1; end
          OP_HLT: begin w_ctrl.halt = 1'b1; w_next = HALTED; end
          default: ;
        endcase
      end
      T3: begin
        case (w_op)
          OP_LDA: begin w_ctrl.ram_out = 1'b1; w_ctrl.a_in = 1'b1; end
          OP_STA: begin w_ctrl.a_out = 1'b1; w_ctrl.ram_in = 1'b1; end
          OP_ADD, OP_SUB: begin
            w_ctrl.ram_out = 1'b1; w_ctrl.b_in = 1'b1;
            w_ctrl.alu_sub = (w_op == OP_SUB);
            w_next = T4;
          end
          default: ;
        endcase
      end
      T4: begin
        if (w_op == OP_ADD || w_op == OP_SUB) begin
          w_ctrl.alu_out = 1'b1; w_ctrl.a_in = 1'b1; w_ctrl.flags_in = 1'b1;
          w_ctrl.alu_sub = (w_op == OP_SUB);
        end
      end
      HALTED: begin
        w_ctrl.halt = 1'b1;
        w_next = HALTED;
      end
      default: w_next = T0;
    endcase
  end

  // Clear forces every strobe low immediately, not just from the next edge
  assign w_gated = i_CLEAR ? '0 : w_ctrl;

  assign o_PC_OUT   = w_gated.pc_out;
  assign o_PC_INC   = w_gated.pc_inc;
  assign o_PC_LOAD  = w_gated.pc_load;
  assign o_MAR_IN   = w_gated.mar_in;
  assign o_RAM_OUT  = w_gated.ram_out;
  assign o_RAM_IN   = w_gated.ram_in;
  assign o_IR_IN    = w_gated.ir_in;
  assign o_IR_OUT   = w_gated.ir_out;
  assign o_A_IN     = w_gated.a_in;
  assign o_A_OUT    = w_gated.a_out;
  assign o_B_IN     = w_gated.b_in;
  assign o_ALU_OUT  = w_gated.alu_out;
  assign o_ALU_SUB  = w_gated.alu_sub;
  assign o_FLAGS_IN = w_gated.flags_in;
  assign o_OUT_IN   = w_gated.out_in;
  assign o_HALT     = w_gated.halt;
  assign o_STEP     = i_CLEAR ? 3'd0 : (r_state == HALTED) ? 3'd2 : r_state;

endmodule
